// File: rtl/ntr_pkg.sv
// Shared definitions for the NTR command capture block: FSM encoding,
// bus width and the default LED-write opcode.
package ntr_pkg;

   localparam int NTR_BYTE_W = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RECV  = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   localparam logic [NTR_BYTE_W-1:0] LED_OPCODE_DEF = 8'hFF;

endpackage

// File: rtl/ntr_cmd_capture_sync_filter.sv
// Brings the asynchronous NTR pins into the clk domain, debounces the byte
// clock and produces a one-cycle strobe on each accepted rising edge.
module ntr_sync_filter
   import ntr_pkg::*;
#(
   parameter int DEBOUNCE = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ntr_clk,
   input  logic                  ntr_cs1,
   input  logic [NTR_BYTE_W-1:0] ntr_data,
   output logic                  byte_strobe,
   output logic [NTR_BYTE_W-1:0] sync_byte,
   output logic                  cs_sync
);

   logic                  clk_p0, clk_p1;
   logic                  cs_p0, cs_p1;
   logic [NTR_BYTE_W-1:0] data_p0, data_p1;
   logic                  fclk, fclk_prev;

   // Synchroniser stage: presets to the idle bus levels (clock and CS high).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clk_p0 <= 1'b1;
         clk_p1 <= 1'b1;
         cs_p0  <= 1'b1;
         cs_p1  <= 1'b1;
      end else begin
         clk_p0 <= ntr_clk;
         clk_p1 <= clk_p0;
         cs_p0  <= ntr_cs1;
         cs_p1  <= cs_p0;
      end
   end

   always_ff @(posedge clk) begin
      data_p0 <= ntr_data;
      data_p1 <= data_p0;
   end

   // Filter stage: fclk follows the synchronised clock only after it has
   // disagreed for DEBOUNCE consecutive cycles.
   generate
      if (DEBOUNCE == 0) begin : g_nofilt
         always_ff @(posedge clk) begin
            if (!rst_n) fclk <= 1'b1;
            else        fclk <= clk_p1;
         end
      end else begin : g_filt
         localparam int CNT_W = $clog2(DEBOUNCE + 1);
         logic [CNT_W-1:0] cnt;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               fclk <= 1'b1;
               cnt  <= '0;
            end else if (fclk != clk_p1) begin
               if (cnt == CNT_W'(DEBOUNCE - 1)) begin
                  fclk <= clk_p1;
                  cnt  <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end else begin
               cnt <= '0;
            end
         end
      end
   endgenerate

   // Edge-detect stage.
   always_ff @(posedge clk) begin
      if (!rst_n) fclk_prev <= 1'b1;
      else        fclk_prev <= fclk;
   end

   assign byte_strobe = fclk & ~fclk_prev & ~cs_p1;
   assign sync_byte   = data_p1;
   assign cs_sync     = cs_p1;

endmodule

// File: rtl/ntr_cmd_capture.sv
// Assembles NTR commands of CMD_BYTES bytes, hands them over on a
// valid/ready interface, decodes LED writes and flags aborts/overruns.
module ntr_cmd_capture
   import ntr_pkg::*;
#(
   parameter int                    CMD_BYTES  = 8,
   parameter int                    NUM_LEDS   = 4,
   parameter int                    DEBOUNCE   = 2,
   parameter logic [NTR_BYTE_W-1:0] LED_OPCODE = LED_OPCODE_DEF
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               ntr_clk,
   input  logic                               ntr_cs1,
   input  logic [NTR_BYTE_W-1:0]              ntr_data,
   output logic [NTR_BYTE_W*CMD_BYTES-1:0]    cmd,
   output logic                               cmd_valid,
   input  logic                               cmd_ready,
   output logic [$clog2(CMD_BYTES+1)-1:0]     byte_count,
   output logic [NUM_LEDS-1:0]                leds,
   output logic                               abort,
   output logic                               overrun
);

   localparam int CW = $clog2(CMD_BYTES + 1);
   localparam int IW = $clog2(CMD_BYTES);

   logic                            strobe;
   logic [NTR_BYTE_W-1:0]           sbyte;
   logic                            cs_sync;
   logic                            cs_prev;
   logic [1:0]                      state;
   logic [NTR_BYTE_W*CMD_BYTES-1:0] asm_q;
   logic [NTR_BYTE_W*CMD_BYTES-1:0] asm_next;
   logic [IW-1:0]                   idx;
   logic                            cs_low;
   logic                            cs_fall;
   logic                            handshake;
   logic                            last_byte;

   ntr_sync_filter #(
      .DEBOUNCE (DEBOUNCE)
   ) u_sync (
      .clk         (clk),
      .rst_n       (rst_n),
      .ntr_clk     (ntr_clk),
      .ntr_cs1     (ntr_cs1),
      .ntr_data    (ntr_data),
      .byte_strobe (strobe),
      .sync_byte   (sbyte),
      .cs_sync     (cs_sync)
   );

   assign cs_low    = ~cs_sync;
   assign cs_fall   = cs_low & cs_prev;
   assign handshake = cmd_valid & cmd_ready;
   assign last_byte = (byte_count == CW'(CMD_BYTES - 1));
   assign idx       = byte_count[IW-1:0];

   // Bytes are gathered in a separate buffer so an aborted command never
   // disturbs the command currently presented on cmd.
   always_comb begin
      asm_next = asm_q;
      asm_next[{idx, 3'b000} +: NTR_BYTE_W] = sbyte;
   end

   always_ff @(posedge clk) begin
      if ((state == ST_RECV || state == ST_IDLE) && cs_low && strobe) asm_q <= asm_next;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cmd        <= '0;
         cmd_valid  <= 1'b0;
         byte_count <= '0;
         leds       <= '0;
         abort      <= 1'b0;
         overrun    <= 1'b0;
         cs_prev    <= 1'b1;
      end else begin
         abort   <= 1'b0;
         overrun <= 1'b0;
         cs_prev <= cs_sync;
         if (handshake) cmd_valid <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (cs_low) begin
                  state <= ST_RECV;
                  if (strobe) byte_count <= CW'(1);
               end
            end
            ST_RECV: begin
               // A strobe implies CS is low, so a final byte always wins over release.
               if (strobe) begin
                  byte_count <= byte_count + 1'b1;
                  if (last_byte) begin
                     state     <= ST_HOLD;
                     cmd       <= asm_next;
                     cmd_valid <= 1'b1;
                     if (asm_q[NTR_BYTE_W-1:0] == LED_OPCODE) leds <= sbyte[NUM_LEDS-1:0];
                  end
               end else if (!cs_low) begin
                  abort      <= 1'b1;
                  byte_count <= '0;
                  state      <= ST_IDLE;
               end
            end
            ST_HOLD: begin
               if (handshake) begin
                  if (cs_low) begin
                     state <= ST_DRAIN;
                  end else begin
                     state      <= ST_IDLE;
                     byte_count <= '0;
                  end
               end else if (cs_fall) begin
                  overrun <= 1'b1;
               end
            end
            ST_DRAIN: begin
               if (!cs_low) begin
                  state      <= ST_IDLE;
                  byte_count <= '0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ntr_cmd_capture.sv
// Directed bench for ntr_cmd_capture: full commands, abort, overrun,
// clock glitch rejection, data phase, non-LED opcode and mid-command reset.
module tb_ntr_cmd_capture;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ntr_clk;
   logic        ntr_cs1;
   logic [7:0]  ntr_data;
   logic        cmd_ready;
   logic [63:0] cmd;
   logic        cmd_valid;
   logic [3:0]  byte_count;
   logic [3:0]  leds;
   logic        abort;
   logic        overrun;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          hs_cnt = 0;
   int          vld_cnt = 0;
   int          abort_cnt = 0;
   int          ovr_cnt = 0;
   logic        vld_prev = 1'b0;
   logic [63:0] last_cmd = '0;

   always #5 clk = ~clk;

   ntr_cmd_capture #(
      .CMD_BYTES  (8),
      .NUM_LEDS   (4),
      .DEBOUNCE   (2),
      .LED_OPCODE (8'hFF)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ntr_clk    (ntr_clk),
      .ntr_cs1    (ntr_cs1),
      .ntr_data   (ntr_data),
      .cmd        (cmd),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .byte_count (byte_count),
      .leds       (leds),
      .abort      (abort),
      .overrun    (overrun)
   );

   // Event monitor, sampled on the inactive edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (cmd_valid && !vld_prev) vld_cnt++;
         if (cmd_valid && cmd_ready) begin
            hs_cnt++;
            last_cmd = cmd;
         end
         if (abort)   abort_cnt++;
         if (overrun) ovr_cnt++;
      end
      vld_prev = cmd_valid;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      ntr_data = b;
      ntr_clk  = 1'b0;
      tick(8);
      ntr_clk  = 1'b1;
      tick(8);
   endtask

   task automatic send_cmd(input logic [63:0] c);
      for (int i = 0; i < 8; i++) send_byte(c[8*i +: 8]);
   endtask

   initial begin
      rst_n     = 1'b0;
      ntr_clk   = 1'b1;
      ntr_cs1   = 1'b1;
      ntr_data  = 8'h00;
      cmd_ready = 1'b1;
      tick(4);
      chk("rst_cmd", cmd, 64'h0);
      chk("rst_valid", cmd_valid, 0);
      chk("rst_count", byte_count, 0);
      chk("rst_leds", leds, 0);
      chk("rst_abort", abort, 0);
      chk("rst_overrun", overrun, 0);
      rst_n = 1'b1;
      tick(4);

      // Basic LED command with immediate handshake.
      ntr_cs1 = 1'b0;
      tick(4);
      send_cmd(64'h01000000000000FF);
      tick(4);
      chk("t1_hs", hs_cnt, 1);
      chk("t1_vld_rise", vld_cnt, 1);
      chk("t1_cmd", last_cmd, 64'h01000000000000FF);
      chk("t1_leds", leds, 4'b0001);
      chk("t1_valid_low", cmd_valid, 0);
      chk("t1_count_drain", byte_count, 8);
      ntr_cs1 = 1'b1;
      tick(8);
      chk("t1_count_idle", byte_count, 0);
      chk("t1_no_abort", abort_cnt, 0);

      // Partial command then release: abort.
      ntr_cs1 = 1'b0;
      tick(4);
      send_byte(8'h9F);
      send_byte(8'h11);
      send_byte(8'h22);
      chk("t2_count3", byte_count, 3);
      ntr_cs1 = 1'b1;
      tick(8);
      chk("t2_abort", abort_cnt, 1);
      chk("t2_valid", cmd_valid, 0);
      chk("t2_vld_rise", vld_cnt, 1);
      chk("t2_leds", leds, 4'b0001);
      chk("t2_count0", byte_count, 0);
      chk("t2_cmd_kept", cmd, 64'h01000000000000FF);
      ntr_cs1 = 1'b0;
      tick(4);
      send_cmd(64'h0A060504030201FF);
      tick(4);
      chk("t2_hs", hs_cnt, 2);
      chk("t2_cmd", last_cmd, 64'h0A060504030201FF);
      chk("t2_leds_new", leds, 4'b1010);
      ntr_cs1 = 1'b1;
      tick(8);

      // Overrun: second command while the first is still unacknowledged.
      cmd_ready = 1'b0;
      ntr_cs1 = 1'b0;
      tick(4);
      send_cmd(64'h07060504030201A5);
      ntr_cs1 = 1'b1;
      tick(8);
      chk("t3_valid_hold", cmd_valid, 1);
      chk("t3_cmd_hold", cmd, 64'h07060504030201A5);
      ntr_cs1 = 1'b0;
      tick(4);
      send_cmd(64'h5555555555555555);
      chk("t3_overrun", ovr_cnt, 1);
      chk("t3_cmd_kept", cmd, 64'h07060504030201A5);
      chk("t3_valid_still", cmd_valid, 1);
      chk("t3_count", byte_count, 8);
      ntr_cs1 = 1'b1;
      tick(8);
      cmd_ready = 1'b1;
      tick(4);
      chk("t3_hs", hs_cnt, 3);
      chk("t3_delivered", last_cmd, 64'h07060504030201A5);
      chk("t3_valid_low", cmd_valid, 0);
      chk("t3_count0", byte_count, 0);
      chk("t3_leds", leds, 4'b1010);
      chk("t3_ovr_once", ovr_cnt, 1);
      chk("t3_vld_rise", vld_cnt, 3);

      // Single-cycle clock glitch between real edges.
      ntr_cs1 = 1'b0;
      tick(4);
      send_byte(8'hFF);
      chk("t4_count1", byte_count, 1);
      ntr_data = 8'h33;
      ntr_clk  = 1'b0;
      tick(6);
      ntr_clk  = 1'b1;
      tick(1);
      ntr_clk  = 1'b0;
      tick(6);
      chk("t4_glitch", byte_count, 1);
      ntr_clk  = 1'b1;
      tick(8);
      chk("t4_count2", byte_count, 2);
      ntr_cs1 = 1'b1;
      tick(8);
      chk("t4_abort", abort_cnt, 2);
      chk("t4_count0", byte_count, 0);

      // Command followed by data-phase strobes under the same CS.
      ntr_cs1 = 1'b0;
      tick(4);
      send_cmd(64'h03605040302010FF);
      for (int i = 0; i < 4; i++) send_byte(8'hEE);
      chk("t5_hs", hs_cnt, 4);
      chk("t5_vld_rise", vld_cnt, 4);
      chk("t5_cmd", last_cmd, 64'h03605040302010FF);
      chk("t5_cmd_stable", cmd, 64'h03605040302010FF);
      chk("t5_leds", leds, 4'b0011);
      chk("t5_count_drain", byte_count, 8);
      chk("t5_no_abort", abort_cnt, 2);
      ntr_cs1 = 1'b1;
      tick(8);
      chk("t5_count0", byte_count, 0);

      // Non-LED opcode.
      ntr_cs1 = 1'b0;
      tick(4);
      send_cmd(64'h0F0605040302019F);
      tick(4);
      chk("t6_hs", hs_cnt, 5);
      chk("t6_cmd", last_cmd, 64'h0F0605040302019F);
      chk("t6_leds", leds, 4'b0011);
      ntr_cs1 = 1'b1;
      tick(8);

      // Reset in the middle of a command.
      ntr_cs1 = 1'b0;
      tick(4);
      send_byte(8'hFF);
      send_byte(8'h01);
      send_byte(8'h02);
      chk("t7_count3", byte_count, 3);
      rst_n = 1'b0;
      tick(1);
      chk("t7_cmd", cmd, 64'h0);
      chk("t7_valid", cmd_valid, 0);
      chk("t7_count", byte_count, 0);
      chk("t7_leds", leds, 0);
      chk("t7_abort", abort, 0);
      chk("t7_overrun", overrun, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ntr_cmd_capture.md
Name: ntr_cmd_capture

Overview:
- Captures NTR parallel-bus commands in the system clock domain, using a configurable command length.
- Synchronises and filters the NTR byte clock, then assembles the command.
- Presents the finished command over a valid/ready handshake and decodes the LED opcode into a NUM_LEDS-wide LED register.
- Reports aborted commands and overruns. Sits between the cartridge pins and the top-level command consumer.

Parameters:
- CMD_BYTES, 8, number of bytes per command (2..16).
- NUM_LEDS, 4, LED register width (1..8).
- DEBOUNCE, 2, consecutive clk cycles a synchronised ntr_clk level must hold before it is accepted. 0 means no filtering.
- LED_OPCODE, 8'hFF, byte-0 value that selects the LED-write command.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ntr_clk  in  1  asynchronous NTR byte clock.
- ntr_cs1  in  1  asynchronous chip select, active low.
- ntr_data  in  8  asynchronous NTR data bus.
- cmd  out  8*CMD_BYTES  assembled command. Byte k is at cmd[8k+7:8k]; byte 0 is the first byte received.
- cmd_valid  out  1  command available.
- cmd_ready  in  1  consumer accepts the command.
- byte_count  out  $clog2(CMD_BYTES+1)  bytes latched so far in the current command.
- leds  out  NUM_LEDS  LED register.
- abort  out  1  one-cycle pulse: chip select released with a partial command.
- overrun  out  1  one-cycle pulse: a new command started while cmd_valid was still unacknowledged.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; cmd=0; cmd_valid=0; byte_count=0; leds=0; abort=0; overrun=0.
  - The synchroniser and filter preset to ntr_clk=1 and cs1=1.
  - Reset mid-command discards the partial command.
- Input conditioning:
  - ntr_clk, ntr_cs1 and ntr_data each pass through a 2-FF synchroniser.
  - The filtered clock (fclk) takes the synchronised level after it has differed from fclk for DEBOUNCE consecutive cycles.
  - byte_strobe = fclk rose this cycle AND synchronised cs1 == 0.
  - On byte_strobe, the synchronised data from that same cycle is latched.
- FSM states and transitions:
  - IDLE: cs1 low -> RECV.
  - RECV:
    - On byte_strobe, write byte[byte_count] and increment byte_count.
    - When the CMD_BYTES-th byte is written, the next state is HOLD and cmd_valid=1 on the following cycle.
    - cs1 high before completion: pulse abort, clear byte_count, go to IDLE. cmd and cmd_valid are unchanged.
  - HOLD:
    - cmd_valid stays 1 and cmd is stable until cmd_valid & cmd_ready.
    - Further strobes in the same CS cycle (the data phase) are ignored.
    - cs1 high -> wait for the handshake, then go to IDLE.
    - Handshake while cs1 is low -> DRAIN.
  - DRAIN: ignore strobes; cs1 high -> IDLE.
- Handshake:
  - cmd_valid falls the cycle after cmd_valid & cmd_ready.
  - cmd_ready without cmd_valid has no effect.
  - cmd_valid never depends combinationally on cmd_ready.
- Overrun:
  - Condition: cs1 goes low (a new command) while cmd_valid=1 and no handshake is pending.
  - Pulse overrun and stay in HOLD. The new command's bytes are dropped; the old cmd is preserved.
  - Return to IDLE only after the handshake and cs1 high.
- LED decode:
  - On the cycle of entry into HOLD, if byte0 == LED_OPCODE, leds <= byte[CMD_BYTES-1][NUM_LEDS-1:0].
  - The LED update does not depend on the handshake.
  - Any other opcode leaves leds unchanged.
- Latency:
  - Pin edge to byte_strobe: 2 + DEBOUNCE clk cycles (±1 for synchronisation).
  - Last byte_strobe to cmd_valid=1: 1 cycle.
- byte_count:
  - Saturates at CMD_BYTES.
  - Clears on return to IDLE and on abort.
  - When CMD_BYTES is a power of two it never wraps.
- Simultaneous events: if the last byte and cs1 release occur in the same cycle, the byte completes the command (HOLD, no abort).

Decomposition:
- Package ntr_pkg: state encoding (IDLE, RECV, HOLD, DRAIN), NTR_BYTE_W=8, default LED_OPCODE.
- Sub-module ntr_sync_filter: 2-FF synchroniser for clk, cs1 and data, DEBOUNCE filter on the clock, rise-edge detect. Output is byte_strobe plus the synchronised byte.

Test Plan:
- Reset, then send 8 bytes FF,00,00,00,00,00,00,01 with cmd_ready=1 -> cmd_valid pulses once, cmd=64'h01000000000000FF, leds=4'b0001, byte_count returns to 0 after cs1 high.
- Send 3 bytes, then raise cs1 -> abort pulses for 1 cycle, cmd_valid stays 0, leds are unchanged, the next full command is captured correctly.
- cmd_ready=0; send a full command, release cs1, start a second command -> overrun pulses once. The first cmd is held. After cmd_ready=1 the first command is delivered and the second is dropped.
- DEBOUNCE=2: insert a 1-cycle ntr_clk glitch (after synchronisation) between real edges -> no extra byte latched, byte_count advances by exactly 1 per real edge.
- 8 command bytes followed by 4 data-phase strobes under the same CS -> exactly one cmd_valid. The extra bytes do not alter cmd. DRAIN is entered if the handshake happens before cs1 rises.
- Opcode 8'h9F with last byte 8'h0F -> cmd is delivered, leds unchanged. Drive rst_n=0 mid-command -> all outputs are 0 on the next cycle.
